// File: rtl/pll_drp_seq.sv
// ---------------------------------------------------------------------------
// pll_drp_seq
// Parametrised PLL reconfiguration sequencer. A select strobe holds the PLL in
// reset, read-modify-writes NREG DRP registers using an external config table,
// then releases the PLL reset and waits for LOCKED. Every wait has a timeout.
//
// Ports
//   clk_i        single clock, also the PLL DCLK
//   rst_i        asynchronous active-high reset
//   sel_i/sen_i  requested configuration and its 1-cycle strobe
//   busy_o       high from an accepted strobe until srdy_o
//   srdy_o       1-cycle pulse at sequence end (success, timeout or rejection)
//   err_o        sticky error, cleared by the next accepted strobe
//   cur_cfg_o    last configuration fully written and locked
//   tbl_cfg_o    config-table lookup index (configuration)
//   tbl_reg_o    config-table lookup index (register 0..NREG-1)
//   tbl_daddr_i  DRP address for the current table entry
//   tbl_mask_i   1 = keep the bit read back, 0 = take it from tbl_bits_i
//   tbl_bits_i   replacement bit values
//   daddr_o, di_o, do_i, den_o, dwe_o, drdy_i   DRP port
//   rst_pll_o    PLL reset
//   locked_i     PLL lock indication
// ---------------------------------------------------------------------------
module pll_drp_seq #(
   parameter int NCFG    = 16,
   parameter int SEL_W   = 4,
   parameter int NREG    = 23,
   parameter int REG_W   = 5,
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 16,
   parameter int DRDY_TO = 255,
   parameter int LOCK_TO = 65535
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [SEL_W-1:0]  sel_i,
   input  logic              sen_i,
   output logic              busy_o,
   output logic              srdy_o,
   output logic              err_o,
   output logic [SEL_W-1:0]  cur_cfg_o,
   output logic [SEL_W-1:0]  tbl_cfg_o,
   output logic [REG_W-1:0]  tbl_reg_o,
   input  logic [ADDR_W-1:0] tbl_daddr_i,
   input  logic [DATA_W-1:0] tbl_mask_i,
   input  logic [DATA_W-1:0] tbl_bits_i,
   output logic [ADDR_W-1:0] daddr_o,
   output logic [DATA_W-1:0] di_o,
   input  logic [DATA_W-1:0] do_i,
   output logic              den_o,
   output logic              dwe_o,
   input  logic              drdy_i,
   output logic              rst_pll_o,
   input  logic              locked_i
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_PRST  = 3'd1;
   localparam logic [2:0] ST_RD    = 3'd2;
   localparam logic [2:0] ST_RDW   = 3'd3;
   localparam logic [2:0] ST_WR    = 3'd4;
   localparam logic [2:0] ST_WRW   = 3'd5;
   localparam logic [2:0] ST_LOCKW = 3'd6;

   // One counter serves both wait kinds, so size it for the longer timeout.
   localparam int TO_MAX = (DRDY_TO > LOCK_TO) ? DRDY_TO : LOCK_TO;
   localparam int CNT_W  = $clog2(TO_MAX + 1);
   localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TO - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TO - 1);
   localparam logic [REG_W-1:0] REG_LAST  = REG_W'(NREG - 1);
   localparam logic [SEL_W:0]   NCFG_EXT  = (SEL_W + 1)'(NCFG);

   logic [2:0]        state_q, state_d;
   logic              busy_q, busy_d;
   logic              srdy_q, srdy_d;
   logic              err_q, err_d;
   logic [SEL_W-1:0]  cur_cfg_q, cur_cfg_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [REG_W-1:0]  idx_q, idx_d;
   logic [ADDR_W-1:0] daddr_q, daddr_d;
   logic [DATA_W-1:0] di_q, di_d;
   logic              den_q, den_d;
   logic              dwe_q, dwe_d;
   logic              rst_pll_q, rst_pll_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              sel_ok;

   assign sel_ok = ({1'b0, sel_i} < NCFG_EXT);

   // Next-state logic. DEN/DWE default low so each DRP access is a single
   // cycle pulse. A DRDY timeout also drops the PLL reset, leaving the PLL
   // running with whatever was partially written.
   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      srdy_d    = 1'b0;
      err_d     = err_q;
      cur_cfg_d = cur_cfg_q;
      sel_d     = sel_q;
      idx_d     = idx_q;
      daddr_d   = daddr_q;
      di_d      = di_q;
      den_d     = 1'b0;
      dwe_d     = 1'b0;
      rst_pll_d = rst_pll_q;
      cnt_d     = cnt_q;
      case (state_q)
         ST_IDLE: begin
            rst_pll_d = 1'b0;
            if (sen_i) begin
               if (sel_ok) begin
                  sel_d     = sel_i;
                  err_d     = 1'b0;
                  busy_d    = 1'b1;
                  rst_pll_d = 1'b1;
                  idx_d     = '0;
                  state_d   = ST_PRST;
               end else begin
                  err_d  = 1'b1;
                  srdy_d = 1'b1;
               end
            end
         end
         ST_PRST: state_d = ST_RD;
         ST_RD: begin
            den_d   = 1'b1;
            daddr_d = tbl_daddr_i;
            cnt_d   = '0;
            state_d = ST_RDW;
         end
         ST_RDW: begin
            if (drdy_i) begin
               di_d    = (do_i & tbl_mask_i) | (tbl_bits_i & ~tbl_mask_i);
               state_d = ST_WR;
            end else if (cnt_q == DRDY_LAST) begin
               err_d     = 1'b1;
               rst_pll_d = 1'b0;
               srdy_d    = 1'b1;
               busy_d    = 1'b0;
               state_d   = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_WR: begin
            den_d   = 1'b1;
            dwe_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_WRW;
         end
         ST_WRW: begin
            if (drdy_i) begin
               if (idx_q == REG_LAST) begin
                  rst_pll_d = 1'b0;
                  cnt_d     = '0;
                  state_d   = ST_LOCKW;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = ST_RD;
               end
            end else if (cnt_q == DRDY_LAST) begin
               err_d     = 1'b1;
               rst_pll_d = 1'b0;
               srdy_d    = 1'b1;
               busy_d    = 1'b0;
               state_d   = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_LOCKW: begin
            if (locked_i) begin
               cur_cfg_d = sel_q;
               srdy_d    = 1'b1;
               busy_d    = 1'b0;
               state_d   = ST_IDLE;
            end else if (cnt_q == LOCK_LAST) begin
               err_d   = 1'b1;
               srdy_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers. Reset holds the PLL in reset; it is released by the
   // IDLE branch on the first clock edge after reset falls.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         busy_q    <= 1'b0;
         srdy_q    <= 1'b0;
         err_q     <= 1'b0;
         cur_cfg_q <= '0;
         sel_q     <= '0;
         idx_q     <= '0;
         daddr_q   <= '0;
         di_q      <= '0;
         den_q     <= 1'b0;
         dwe_q     <= 1'b0;
         rst_pll_q <= 1'b1;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         srdy_q    <= srdy_d;
         err_q     <= err_d;
         cur_cfg_q <= cur_cfg_d;
         sel_q     <= sel_d;
         idx_q     <= idx_d;
         daddr_q   <= daddr_d;
         di_q      <= di_d;
         den_q     <= den_d;
         dwe_q     <= dwe_d;
         rst_pll_q <= rst_pll_d;
         cnt_q     <= cnt_d;
      end
   end

   assign busy_o    = busy_q;
   assign srdy_o    = srdy_q;
   assign err_o     = err_q;
   assign cur_cfg_o = cur_cfg_q;
   assign tbl_cfg_o = sel_q;
   assign tbl_reg_o = idx_q;
   assign daddr_o   = daddr_q;
   assign di_o      = di_q;
   assign den_o     = den_q;
   assign dwe_o     = dwe_q;
   assign rst_pll_o = rst_pll_q;

endmodule

// File: tb/tb_pll_drp_seq.sv
module tb_pll_drp_seq;

   localparam int NCFG    = 12;
   localparam int SEL_W   = 4;
   localparam int NREG    = 5;
   localparam int REG_W   = 3;
   localparam int ADDR_W  = 5;
   localparam int DATA_W  = 16;
   localparam int DRDY_TO = 20;
   localparam int LOCK_TO = 60;

   logic              clock = 1'b0;
   logic              reset;
   logic [SEL_W-1:0]  selIn;
   logic              senIn;
   logic              busy, srdy, err;
   logic [SEL_W-1:0]  curCfg, tblCfg;
   logic [REG_W-1:0]  tblReg;
   logic [ADDR_W-1:0] tblDaddr;
   logic [DATA_W-1:0] tblMask, tblBits;
   logic [ADDR_W-1:0] daddr;
   logic [DATA_W-1:0] di, doData;
   logic              den, dwe, drdy, rstPll, locked;

   // Model-side state and observation logs
   bit          drpDead = 1'b0;
   bit          lockEnable = 1'b1;
   bit          forceUnlock = 1'b0;
   int          drdyDelay = 0;
   int          lockCnt = 0;
   int          denCount = 0;
   int          srdyCount = 0;
   logic [21:0] logQ[$];

   int vectorCount = 0;
   int missCount = 0;

   always #5 clock = ~clock;

   // Config table: register r lives at DRP address 8+r for every configuration
   assign tblDaddr = 5'd8 + {2'b00, tblReg};
   assign tblMask  = 16'hFF00;
   assign tblBits  = 16'h00AB;
   assign doData   = 16'h1234;

   pll_drp_seq #(
      .NCFG(NCFG), .SEL_W(SEL_W), .NREG(NREG), .REG_W(REG_W), .ADDR_W(ADDR_W),
      .DATA_W(DATA_W), .DRDY_TO(DRDY_TO), .LOCK_TO(LOCK_TO)
   ) dut (
      .clk_i(clock), .rst_i(reset), .sel_i(selIn), .sen_i(senIn),
      .busy_o(busy), .srdy_o(srdy), .err_o(err), .cur_cfg_o(curCfg),
      .tbl_cfg_o(tblCfg), .tbl_reg_o(tblReg), .tbl_daddr_i(tblDaddr),
      .tbl_mask_i(tblMask), .tbl_bits_i(tblBits), .daddr_o(daddr), .di_o(di),
      .do_i(doData), .den_o(den), .dwe_o(dwe), .drdy_i(drdy),
      .rst_pll_o(rstPll), .locked_i(locked)
   );

   // DRP and PLL model: DRDY two cycles after each DEN, LOCKED ten cycles
   // after the PLL reset falls; every DEN is logged as {dwe, daddr, di}.
   always @(negedge clock) begin
      drdy = 1'b0;
      if (drdyDelay > 0) begin
         drdyDelay--;
         if (drdyDelay == 0) drdy = 1'b1;
      end
      if (den === 1'b1) begin
         logQ.push_back({dwe, daddr, di});
         denCount++;
         if (!drpDead) drdyDelay = 2;
      end
      if (srdy === 1'b1) srdyCount++;
      if (rstPll !== 1'b0) begin
         lockCnt = 0;
         locked  = 1'b0;
      end else if (lockEnable) begin
         if (lockCnt < 10) lockCnt++;
         locked = (lockCnt >= 10) && !forceUnlock;
      end else begin
         locked = 1'b0;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [SEL_W-1:0] sel);
      @(negedge clock);
      selIn = sel;
      senIn = 1'b1;
      @(negedge clock);
      senIn = 1'b0;
   endtask

   task automatic waitSrdy(input int budget, output bit got);
      got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock);
         if (srdy === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit got;
      int snap;
      reset = 1'b0;
      selIn = '0;
      senIn = 1'b0;
      drdy  = 1'b0;
      locked = 1'b0;
      #2 reset = 1'b1;

      // Reset state and release
      repeat (3) @(negedge clock);
      checkOutput("t1_rstpll", 32'(rstPll), 32'd1);
      checkOutput("t1_busy", 32'(busy), 32'd0);
      checkOutput("t1_curcfg", 32'(curCfg), 32'd0);
      checkOutput("t1_err", 32'(err), 32'd0);
      checkOutput("t1_den", 32'(den), 32'd0);
      checkOutput("t1_srdy", 32'(srdy), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("t1_rstpll_rel", 32'(rstPll), 32'd0);
      repeat (15) @(negedge clock);

      // Full sequence, config 5
      logQ.delete();
      applyStimulus(4'd5);
      checkOutput("t2_busy", 32'(busy), 32'd1);
      checkOutput("t2_rstpll", 32'(rstPll), 32'd1);
      checkOutput("t2_tblcfg", 32'(tblCfg), 32'd5);
      waitSrdy(300, got);
      checkOutput("t2_srdy", 32'(got), 32'd1);
      checkOutput("t2_curcfg", 32'(curCfg), 32'd5);
      checkOutput("t2_err", 32'(err), 32'd0);
      checkOutput("t2_rstpll_end", 32'(rstPll), 32'd0);
      checkOutput("t2_logsize", 32'(logQ.size()), 32'(2 * NREG));
      if (logQ.size() == 2 * NREG) begin
         for (int i = 0; i < NREG; i++) begin
            checkOutput($sformatf("t2_rd%0d", i), 32'(logQ[2*i][21:16]), 32'({1'b0, 5'(8 + i)}));
            checkOutput($sformatf("t2_wr%0d", i), 32'(logQ[2*i+1]), 32'({1'b1, 5'(8 + i), 16'h12AB}));
         end
      end
      @(negedge clock);
      checkOutput("t2_busy_end", 32'(busy), 32'd0);

      // LOCKED drop while idle has no effect
      snap = srdyCount;
      forceUnlock = 1'b1;
      repeat (5) @(negedge clock);
      forceUnlock = 1'b0;
      checkOutput("t2_unlock_busy", 32'(busy), 32'd0);
      checkOutput("t2_unlock_err", 32'(err), 32'd0);
      checkOutput("t2_unlock_srdy", 32'(srdyCount - snap), 32'd0);

      // Rejected selection, then a valid one clears ERR
      snap = denCount;
      applyStimulus(4'd12);
      checkOutput("t3_srdy", 32'(srdy), 32'd1);
      checkOutput("t3_err", 32'(err), 32'd1);
      checkOutput("t3_busy", 32'(busy), 32'd0);
      checkOutput("t3_rstpll", 32'(rstPll), 32'd0);
      repeat (5) @(negedge clock);
      checkOutput("t3_noden", 32'(denCount - snap), 32'd0);
      checkOutput("t3_srdy_once", 32'(srdy), 32'd0);
      applyStimulus(4'd15);
      checkOutput("t3_err15", 32'(err), 32'd1);
      applyStimulus(4'd3);
      checkOutput("t3_errclr", 32'(err), 32'd0);
      waitSrdy(300, got);
      checkOutput("t3_srdy_ok", 32'(got), 32'd1);
      checkOutput("t3_curcfg", 32'(curCfg), 32'd3);

      // DRDY never arrives
      drpDead = 1'b1;
      applyStimulus(4'd7);
      waitSrdy(100, got);
      drpDead = 1'b0;
      checkOutput("t4_srdy", 32'(got), 32'd1);
      checkOutput("t4_err", 32'(err), 32'd1);
      checkOutput("t4_rstpll", 32'(rstPll), 32'd0);
      checkOutput("t4_curcfg", 32'(curCfg), 32'd3);
      checkOutput("t4_busy", 32'(busy), 32'd0);
      repeat (5) @(negedge clock);

      // LOCKED never arrives; a second strobe while busy is ignored
      lockEnable = 1'b0;
      snap = srdyCount;
      applyStimulus(4'd9);
      repeat (4) @(negedge clock);
      applyStimulus(4'd2);
      waitSrdy(300, got);
      checkOutput("t5_srdy", 32'(got), 32'd1);
      checkOutput("t5_err", 32'(err), 32'd1);
      checkOutput("t5_curcfg", 32'(curCfg), 32'd3);
      repeat (150) @(negedge clock);
      checkOutput("t5_single_srdy", 32'(srdyCount - snap), 32'd1);
      checkOutput("t5_busy", 32'(busy), 32'd0);
      lockEnable = 1'b1;
      repeat (15) @(negedge clock);

      // Reset during the write wait of register 3
      applyStimulus(4'd4);
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (tblReg == 3'd3 && dwe === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      checkOutput("t6_reach_wrw3", 32'(got), 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("t6_den", 32'(den), 32'd0);
      checkOutput("t6_rstpll", 32'(rstPll), 32'd1);
      checkOutput("t6_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("t6_rstpll_rel", 32'(rstPll), 32'd0);
      checkOutput("t6_tblreg", 32'(tblReg), 32'd0);
      checkOutput("t6_curcfg", 32'(curCfg), 32'd0);
      repeat (15) @(negedge clock);
      logQ.delete();
      applyStimulus(4'd6);
      checkOutput("t6_restart_reg", 32'(tblReg), 32'd0);
      checkOutput("t6_restart_busy", 32'(busy), 32'd1);
      waitSrdy(300, got);
      checkOutput("t6_srdy", 32'(got), 32'd1);
      checkOutput("t6_curcfg_new", 32'(curCfg), 32'd6);
      checkOutput("t6_logsize", 32'(logQ.size()), 32'(2 * NREG));
      if (logQ.size() > 0)
         checkOutput("t6_first_addr", 32'(logQ[0][21:16]), 32'({1'b0, 5'd8}));

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
